uart_tx_arbiter: RTL and testbench

Shares one UART transmit line between `NUM_REQ` byte producers, such as the message generator and status/debug sources, in the 8 MHz fabric clock domain. Arbitration is round-robin per packet; a granted requester keeps the line until it sends a byte marked `last` or stalls past a hold timeout. The block frames each byte (1 start, 8 data LSB-first, 1 stop) and drives `ser_tx` directly toward the `SER_TX` pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_serializer.sv | 70 +++++++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and frame constants for the arbitrated UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } arb_state_e;

  localparam int   BITS_PER_FRAME = 10;
  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;

  // Frame bits in transmit order: bit 0 goes out first.
  function automatic logic [BITS_PER_FRAME-1:0] build_frame(input logic [7:0] data);
    return {STOP_BIT, data, START_BIT};
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame shifter: loads a byte, emits start/data/stop bits and flags the final stop-bit cycle.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ser_tx,
  output logic       busy,
  output logic       last_cycle
);

  localparam int              TW       = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [3:0]      LAST_IDX = 4'(BITS_PER_FRAME - 1);

  logic [TW-1:0]               r_bit_tmr;
  logic [3:0]                  r_bit_idx;
  logic                        r_busy;
  logic                        r_ser;
  logic [BITS_PER_FRAME-2:0]   r_shift;
  logic [BITS_PER_FRAME-1:0]   w_frame;
  logic                        w_bit_end;

  assign w_frame    = build_frame(data);
  assign w_bit_end  = (r_bit_tmr == '0);
  assign last_cycle = r_busy && (r_bit_idx == LAST_IDX) && w_bit_end;
  assign ser_tx     = r_ser;
  assign busy       = r_busy;

  // A load in the last stop-bit cycle restarts the frame with no idle gap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_tmr <= '0;
      r_bit_idx <= '0;
      r_busy    <= 1'b0;
      r_ser     <= 1'b1;
    end else if (load) begin
      r_bit_tmr <= TMR_LOAD;
      r_bit_idx <= '0;
      r_busy    <= 1'b1;
      r_ser     <= w_frame[0];
    end else if (r_busy) begin
      if (w_bit_end) begin
        if (r_bit_idx == LAST_IDX) begin
          r_busy <= 1'b0;
          r_ser  <= STOP_BIT;
        end else begin
          r_bit_idx <= r_bit_idx + 4'd1;
          r_ser     <= r_shift[0];
          r_bit_tmr <= TMR_LOAD;
        end
      end else begin
        r_bit_tmr <= r_bit_tmr - TW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (load) begin
      r_shift <= w_frame[BITS_PER_FRAME-1:1];
    end else if (r_busy && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmit line among NUM_REQ byte producers.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int CLOCKS_PER_BIT = 8,
  parameter int HOLD_TIMEOUT   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 ser_tx
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);

  arb_state_e         r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [PW-1:0]      r_owner;
  logic [PW-1:0]      r_rr_ptr;
  logic               r_last;
  logic [HW-1:0]      r_hold_tmr;

  logic               w_win_found;
  logic [PW-1:0]      w_win_idx;
  logic [PW-1:0]      w_next_ptr;
  logic               w_owner_vld;
  logic               w_arb_en;
  logic               w_own_en;
  logic               w_last_cycle;
  logic               w_load;
  logic [PW-1:0]      w_sel;
  logic [7:0]         w_load_data;
  logic [NUM_REQ-1:0] w_ready;

  // Scan downward so the smallest offset from the pointer is the one that sticks.
  function automatic logic [PW:0] pick_winner(input logic [NUM_REQ-1:0] vld,
                                              input logic [PW-1:0] ptr);
    logic [PW:0] res;
    int          j;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (vld[j]) res = {1'b1, PW'(j)};
    end
    return res;
  endfunction

  assign {w_win_found, w_win_idx} = pick_winner(req_valid, r_rr_ptr);
  assign w_next_ptr  = (w_win_idx == PW'(NUM_REQ - 1)) ? '0 : w_win_idx + PW'(1);
  assign w_owner_vld = req_valid[r_owner];

  // Fresh arbitration in IDLE or after a packet's last byte; otherwise only the owner may continue.
  assign w_arb_en = (r_state == IDLE) || ((r_state == SEND) && w_last_cycle && r_last);
  assign w_own_en = (r_state == HOLD) || ((r_state == SEND) && w_last_cycle && !r_last);

  always_comb begin
    w_ready = '0;
    if (w_arb_en && w_win_found) begin
      w_ready[w_win_idx] = 1'b1;
    end else if (w_own_en && w_owner_vld) begin
      w_ready[r_owner] = 1'b1;
    end
  end

  assign req_ready   = w_ready & {NUM_REQ{reset_n}};
  assign w_load      = |req_ready;
  assign w_sel       = w_arb_en ? w_win_idx : r_owner;
  assign w_load_data = req_data[{w_sel, 3'b000} +: 8];
  assign grant       = r_grant;

  uart_tx_serializer #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_ser (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (w_load),
    .data      (w_load_data),
    .ser_tx    (ser_tx),
    .busy      (busy),
    .last_cycle(w_last_cycle)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_last     <= 1'b0;
      r_hold_tmr <= '0;
    end else if (w_arb_en && w_win_found) begin
      r_grant  <= NUM_REQ'(1) << w_win_idx;
      r_owner  <= w_win_idx;
      r_last   <= req_last[w_win_idx];
      r_rr_ptr <= w_next_ptr;
      r_state  <= SEND;
    end else begin
      case (r_state)
        IDLE: ;
        SEND: begin
          if (w_last_cycle) begin
            if (r_last) begin
              r_grant <= '0;
              r_state <= IDLE;
            end else if (w_owner_vld) begin
              r_last <= req_last[r_owner];
            end else begin
              r_state    <= HOLD;
              r_hold_tmr <= '0;
            end
          end
        end
        HOLD: begin
          // Owner returning in the expiry cycle still wins.
          if (w_owner_vld) begin
            r_last     <= req_last[r_owner];
            r_state    <= SEND;
            r_hold_tmr <= '0;
          end else if (r_hold_tmr == HW'(HOLD_TIMEOUT - 1)) begin
            r_grant    <= '0;
            r_state    <= IDLE;
            r_hold_tmr <= '0;
          end else begin
            r_hold_tmr <= r_hold_tmr + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: accepted bytes are queued and matched against decoded frames.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int CPB = 8;
  localparam int HT  = 16;
  localparam int FL  = 10 * CPB;

  typedef struct {
    int         req;
    logic [7:0] data;
    logic       last;
    int         nb;
  } stim_t;

  typedef struct {
    int         req;
    logic [7:0] data;
    int         hs;
  } exp_t;

  logic            clock;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [NR*8-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            ser_tx;

  stim_t         stim[$];
  exp_t          sb[$];
  int            hs_cyc[$];
  int            hs_idx[$];
  int            fs_cyc[$];
  logic [NR-1:0] glog[int];
  int            rdy_cnt[NR];
  int            busy_cnt;
  int            cyc;
  logic          mon_busy;
  int            n_chk;
  int            n_bad;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .CLOCKS_PER_BIT(CPB),
    .HOLD_TIMEOUT(HT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_last (req_last),
    .req_ready(req_ready),
    .grant    (grant),
    .busy     (busy),
    .ser_tx   (ser_tx)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int find_stim(input int r);
    for (int k = 0; k < stim.size(); k++) begin
      if (stim[k].req == r) return k;
    end
    return -1;
  endfunction

  function automatic int qat(input int q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic [NR-1:0] gget(input int c);
    if (glog.exists(c)) return glog[c];
    return 'x;
  endfunction

  // Requester model: presents queued bytes once their not-before cycle arrives.
  initial begin
    int            k;
    int            cyc_at;
    logic [NR-1:0] hs;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clock);
      cyc_at = cyc;
      for (int i = 0; i < NR; i++) begin
        k = find_stim(i);
        if (k >= 0 && stim[k].nb <= cyc_at) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = stim[k].data;
          req_last[i]        = stim[k].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
      #1;
      glog[cyc_at] = grant;
      if (busy) busy_cnt++;
      for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
      if (req_ready != '0) chk_eq("ready_onehot", $countones(req_ready), 1);
      hs = req_valid & req_ready;
      @(posedge clock);
      if (reset_n) begin
        for (int i = 0; i < NR; i++) begin
          if (hs[i]) begin
            k = find_stim(i);
            if (k >= 0) begin
              sb.push_back('{i, stim[k].data, cyc_at});
              hs_cyc.push_back(cyc_at);
              hs_idx.push_back(i);
              stim.delete(k);
            end
          end
        end
      end
    end
  end

  // Line monitor: checks every cycle of each frame against the expected byte.
  initial begin
    logic [9:0]    expf;
    logic [7:0]    got;
    logic [NR-1:0] gmid;
    exp_t          e;
    int            start;
    int            errs;
    logic          aborted;
    mon_busy = 1'b0;
    forever begin
      @(negedge clock);
      if (reset_n && ser_tx == 1'b0) begin
        mon_busy = 1'b1;
        start    = cyc;
        errs     = 0;
        aborted  = 1'b0;
        got      = '0;
        gmid     = '0;
        chk_eq("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1);
        e.req = 0; e.data = 8'h00; e.hs = 0;
        if (sb.size() > 0) e = sb.pop_front();
        expf = {1'b1, e.data, 1'b0};
        for (int c = 0; c < FL; c++) begin
          if (c > 0) @(negedge clock);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          if (ser_tx !== expf[c / CPB]) errs++;
          if (busy !== 1'b1) errs++;
          if ((c % CPB) == CPB / 2 && c / CPB >= 1 && c / CPB <= 8) got[c / CPB - 1] = ser_tx;
          if (c == FL / 2) gmid = grant;
        end
        if (!aborted) begin
          chk_eq("frame_cycle_errs", errs, 0);
          chk_eq("frame_data", got, e.data);
          chk_eq("frame_latency", start - e.hs, 1);
          chk_eq("frame_grant", gmid, 32'(1) << e.req);
          fs_cyc.push_back(start);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic wait_hs(input int n, input int budget);
    int t;
    t = 0;
    while (hs_idx.size() < n && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk_eq("hs_count", hs_idx.size(), n);
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((stim.size() != 0 || sb.size() != 0 || busy || mon_busy || grant != '0) && t < budget) begin
      @(negedge clock);
      t++;
    end
    chk_eq("idle_reached", (t < budget) ? 1 : 0, 1);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clock);
    stim.delete();
    sb.delete();
    hs_cyc.delete();
    hs_idx.delete();
    fs_cyc.delete();
    busy_cnt = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    reset_n = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    release_reset();
  endtask

  initial begin
    int t0;
    int h;
    int ord2[5];
    int ord3[4];
    n_chk    = 0;
    n_bad    = 0;
    busy_cnt = 0;
    for (int i = 0; i < NR; i++) rdy_cnt[i] = 0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_eq("rst_ser_tx", ser_tx, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_grant", grant, 0);
    chk_eq("rst_ready", req_ready, 0);
    release_reset();

    // Single byte from requester 1.
    t0 = cyc;
    stim.push_back('{1, 8'hA5, 1'b1, t0 + 2});
    wait_hs(1, 20);
    wait_idle(200);
    chk_eq("t1_idx", qat(hs_idx, 0), 1);
    chk_eq("t1_ready_cycles", rdy_cnt[1], 1);
    chk_eq("t1_busy_cycles", busy_cnt, FL);
    chk_eq("t1_grant_end", grant, 0);
    chk_eq("t1_frames", fs_cyc.size(), 1);

    // Round-robin with everyone valid.
    do_reset();
    t0 = cyc;
    for (int i = 0; i < NR; i++) stim.push_back('{i, 8'(8'h10 + i), 1'b1, t0 + 2});
    stim.push_back('{0, 8'h10, 1'b1, t0 + 2});
    wait_hs(5, 600);
    wait_idle(600);
    ord2 = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5; j++) chk_eq("t2_order", qat(hs_idx, j), ord2[j]);
    for (int j = 1; j < 5; j++) chk_eq("t2_start_gap", qat(fs_cyc, j) - qat(fs_cyc, j - 1), FL);

    // Packet lock: requester 2 keeps the line while requester 0 waits.
    do_reset();
    t0 = cyc;
    stim.push_back('{2, 8'h01, 1'b0, t0 + 2});
    stim.push_back('{2, 8'h02, 1'b0, t0 + 2});
    stim.push_back('{2, 8'h03, 1'b1, t0 + 2});
    stim.push_back('{0, 8'h55, 1'b1, t0 + 4});
    wait_hs(4, 600);
    wait_idle(600);
    ord3 = '{2, 2, 2, 0};
    for (int j = 0; j < 4; j++) chk_eq("t3_order", qat(hs_idx, j), ord3[j]);
    chk_eq("t3_req0_after_last", qat(hs_cyc, 3) - qat(hs_cyc, 2), FL);
    chk_eq("t3_ready0_cycles", rdy_cnt[0], 1);
    for (int j = 1; j < 4; j++) chk_eq("t3_contiguous", qat(fs_cyc, j) - qat(fs_cyc, j - 1), FL);

    // Hold timeout: owner 3 stalls, requester 1 takes over after the timeout.
    do_reset();
    t0 = cyc;
    stim.push_back('{3, 8'h3C, 1'b0, t0 + 2});
    stim.push_back('{1, 8'h11, 1'b1, t0 + 4});
    wait_hs(2, 400);
    wait_idle(400);
    h = qat(hs_cyc, 0);
    chk_eq("t4_first", qat(hs_idx, 0), 3);
    chk_eq("t4_second", qat(hs_idx, 1), 1);
    chk_eq("t4_hs_delay", qat(hs_cyc, 1) - h, FL + HT + 1);
    chk_eq("t4_grant_last_hold", gget(h + FL + HT), 4'b1000);
    chk_eq("t4_grant_cleared", gget(h + FL + HT + 1), 4'b0000);

    // Timeout tie: owner returns in the expiry cycle and keeps the line.
    do_reset();
    t0 = cyc;
    stim.push_back('{3, 8'h3C, 1'b0, t0 + 2});
    stim.push_back('{1, 8'h11, 1'b1, t0 + 4});
    wait_hs(1, 20);
    h = qat(hs_cyc, 0);
    stim.push_back('{3, 8'h4D, 1'b1, h + FL + HT});
    wait_hs(3, 600);
    wait_idle(400);
    chk_eq("t5_owner_again", qat(hs_idx, 1), 3);
    chk_eq("t5_tie_cycle", qat(hs_cyc, 1) - h, FL + HT);
    chk_eq("t5_grant_kept", gget(h + FL + HT + 1), 4'b1000);
    chk_eq("t5_req1_after", qat(hs_idx, 2), 1);
    chk_eq("t5_req1_cycle", qat(hs_cyc, 2) - h, 2 * FL + HT);

    // Reset during data bit 4 aborts the frame and restarts arbitration from index 0.
    do_reset();
    t0 = cyc;
    stim.push_back('{1, 8'hC3, 1'b1, t0 + 2});
    wait_hs(1, 20);
    h = qat(hs_cyc, 0);
    while (cyc < h + 44) @(negedge clock);
    #2;
    chk_eq("t6_pre_ser_tx", ser_tx, 0);
    reset_n = 1'b0;
    #1;
    chk_eq("t6_async_ser_tx", ser_tx, 1);
    chk_eq("t6_async_grant", grant, 0);
    chk_eq("t6_async_busy", busy, 0);
    release_reset();
    t0 = cyc;
    stim.push_back('{2, 8'h42, 1'b1, t0 + 2});
    stim.push_back('{0, 8'h81, 1'b1, t0 + 2});
    wait_hs(2, 300);
    wait_idle(400);
    chk_eq("t6_first", qat(hs_idx, 0), 0);
    chk_eq("t6_second", qat(hs_idx, 1), 2);
    chk_eq("t6_frames", fs_cyc.size(), 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
